// File: rtl/traffic_analyzer_mc_regs_pkg.sv
// Register map, response codes and address decode for the traffic analyzer
// CPU register block.
package traffic_analyzer_mc_regs_pkg;

  localparam logic [31:0] RegId        = 32'h000;
  localparam logic [31:0] RegVersion   = 32'h004;
  localparam logic [31:0] RegChanSel   = 32'h008;
  localparam logic [31:0] RegSnapshot  = 32'h00C;
  localparam logic [31:0] RegControl   = 32'h010;
  localparam logic [31:0] RegClear     = 32'h014;
  localparam logic [31:0] RegFrameSize = 32'h100;
  localparam logic [31:0] RegFrameBuf  = 32'h104;
  localparam logic [31:0] RegCntBase   = 32'h200;

  localparam logic [31:0] DefaultRdata = 32'hDEADBEEF;
  localparam logic [1:0]  RespOkay     = 2'b00;
  localparam logic [1:0]  RespSlverr   = 2'b10;

  typedef enum logic [3:0] {
    SelNone,
    SelId,
    SelVersion,
    SelChanSel,
    SelSnapshot,
    SelControl,
    SelClear,
    SelFrameSize,
    SelFrameBuf,
    SelCntHi,
    SelCntLo
  } reg_sel_e;

  // Counter window spans 16 x 8 bytes; index range is checked by the caller.
  function automatic reg_sel_e reg_decode(input logic [31:0] off);
    reg_sel_e sel;
    sel = SelNone;
    case (off)
      RegId:        sel = SelId;
      RegVersion:   sel = SelVersion;
      RegChanSel:   sel = SelChanSel;
      RegSnapshot:  sel = SelSnapshot;
      RegControl:   sel = SelControl;
      RegClear:     sel = SelClear;
      RegFrameSize: sel = SelFrameSize;
      RegFrameBuf:  sel = SelFrameBuf;
      default: begin
        if (off[31:7] == RegCntBase[31:7] && off[1:0] == 2'b00) begin
          sel = off[2] ? SelCntLo : SelCntHi;
        end
      end
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/traffic_analyzer_axil_slave.sv
// AXI-Lite slave handshake: one outstanding write and one outstanding read,
// single-cycle ready pulses, registered responses.
module traffic_analyzer_axil_slave
  import traffic_analyzer_mc_regs_pkg::*;
#(
  parameter int unsigned AddrWidth = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AddrWidth-1:0] awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [AddrWidth-1:0] araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 wr_en,
  output logic [AddrWidth-1:0] wr_addr,
  output logic [31:0]          wr_data,
  output logic [3:0]           wr_strb,
  input  logic                 wr_err,
  output logic                 rd_en,
  output logic [AddrWidth-1:0] rd_addr,
  input  logic [31:0]          rd_data,
  input  logic                 rd_err,
  output logic                 rd_done
);

  logic        wready_q, wready_d;
  logic        bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  assign wr_en   = wready_q & awvalid & wvalid;
  assign wr_addr = awaddr;
  assign wr_data = wdata;
  assign wr_strb = wstrb;
  assign rd_en   = arready_q & arvalid;
  assign rd_addr = araddr;
  assign rd_done = rvalid_q & rready;

  always_comb begin
    wready_d  = awvalid & wvalid & ~wready_q & ~bvalid_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    arready_d = arvalid & ~arready_q & ~rvalid_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (wr_en) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RespSlverr : RespOkay;
    end else if (bvalid_q && bready) begin
      bvalid_d = 1'b0;
    end
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_data;
      rresp_d  = rd_err ? RespSlverr : RespOkay;
    end else if (rd_done) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= 2'b00;
    end else begin
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign awready = wready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: rtl/traffic_analyzer_mc_cpu_regs.sv
// CPU-visible register file for the multi-channel traffic analyzer: channel
// select, per-channel control, atomic counter snapshots and frame buffer access.
module traffic_analyzer_mc_cpu_regs
  import traffic_analyzer_mc_regs_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH        = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH        = 12,
  parameter logic [31:0] C_BASE_ADDRESS            = 32'h0,
  parameter int unsigned C_NUM_CHANNELS            = 4,
  parameter int unsigned C_NUM_COUNTERS            = 8,
  parameter int unsigned C_FRAME_BUF_ADDRESS_WIDTH = 9
) (
  input  logic                                     S_AXI_ACLK,
  input  logic                                     S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                               S_AXI_AWPROT,
  input  logic                                     S_AXI_AWVALID,
  output logic                                     S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                                     S_AXI_WVALID,
  output logic                                     S_AXI_WREADY,
  output logic [1:0]                               S_AXI_BRESP,
  output logic                                     S_AXI_BVALID,
  input  logic                                     S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                               S_AXI_ARPROT,
  input  logic                                     S_AXI_ARVALID,
  output logic                                     S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                               S_AXI_RRESP,
  output logic                                     S_AXI_RVALID,
  input  logic                                     S_AXI_RREADY,
  input  logic [31:0]                              id_reg,
  input  logic [31:0]                              version_reg,
  input  logic [C_NUM_CHANNELS*C_NUM_COUNTERS*64-1:0] counters,
  output logic [C_NUM_CHANNELS*32-1:0]             control,
  output logic [C_NUM_CHANNELS-1:0]                counters_clear,
  input  logic [C_NUM_CHANNELS*32-1:0]             frame_size,
  input  logic [31:0]                              frame_buf_data,
  output logic [C_FRAME_BUF_ADDRESS_WIDTH-1:0]     frame_buf_address,
  output logic [3:0]                               chan_sel
);

  localparam int unsigned AW  = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned FBW = C_FRAME_BUF_ADDRESS_WIDTH;

  logic          wr_en, rd_en, rd_done, wr_err, rd_err;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [31:0]   wr_data, rd_data;
  logic [3:0]    wr_strb;

  logic unused_prot;
  assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  traffic_analyzer_axil_slave #(
    .AddrWidth (AW)
  ) u_axil (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .awaddr  (S_AXI_AWADDR),
    .awvalid (S_AXI_AWVALID),
    .awready (S_AXI_AWREADY),
    .wdata   (S_AXI_WDATA),
    .wstrb   (S_AXI_WSTRB),
    .wvalid  (S_AXI_WVALID),
    .wready  (S_AXI_WREADY),
    .bresp   (S_AXI_BRESP),
    .bvalid  (S_AXI_BVALID),
    .bready  (S_AXI_BREADY),
    .araddr  (S_AXI_ARADDR),
    .arvalid (S_AXI_ARVALID),
    .arready (S_AXI_ARREADY),
    .rdata   (S_AXI_RDATA),
    .rresp   (S_AXI_RRESP),
    .rvalid  (S_AXI_RVALID),
    .rready  (S_AXI_RREADY),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .wr_err  (wr_err),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .rd_done (rd_done)
  );

  logic [3:0]                         chan_sel_q, chan_sel_d;
  logic [C_NUM_CHANNELS-1:0][31:0]    control_q, control_d;
  logic [C_NUM_COUNTERS-1:0][63:0]    snap_q, snap_d;
  logic [C_NUM_CHANNELS-1:0]          clear_q, clear_d;
  logic [FBW-1:0]                     fb_addr_q, fb_addr_d;
  logic                               rd_fbuf_q, rd_fbuf_d;

  logic [31:0] wr_off, rd_off;
  reg_sel_e    wr_sel, rd_sel;
  logic [31:0] cur_control, cur_fsize;

  assign wr_off = 32'(wr_addr ^ C_BASE_ADDRESS[AW-1:0]);
  assign rd_off = 32'(rd_addr ^ C_BASE_ADDRESS[AW-1:0]);
  assign wr_sel = reg_decode(wr_off);
  assign rd_sel = reg_decode(rd_off);

  always_comb begin
    cur_control = 32'h0;
    cur_fsize   = 32'h0;
    for (int c = 0; c < C_NUM_CHANNELS; c++) begin
      if (chan_sel_q == 4'(c)) begin
        cur_control = control_q[c];
        cur_fsize   = frame_size[c*32 +: 32];
      end
    end
  end

  // Combinational read data is sampled at the AR handshake, so a write landing
  // on the same edge is not yet visible.
  always_comb begin
    rd_data = 32'h0;
    rd_err  = 1'b0;
    case (rd_sel)
      SelId:        rd_data = id_reg;
      SelVersion:   rd_data = version_reg;
      SelChanSel:   rd_data = {28'h0, chan_sel_q};
      SelControl:   rd_data = cur_control;
      SelFrameSize: rd_data = cur_fsize;
      SelFrameBuf:  rd_data = frame_buf_data;
      SelSnapshot, SelClear: rd_data = 32'h0;
      SelCntHi, SelCntLo: begin
        rd_err  = 1'b1;
        rd_data = DefaultRdata;
        for (int k = 0; k < C_NUM_COUNTERS; k++) begin
          if (rd_off[6:3] == 4'(k)) begin
            rd_err  = 1'b0;
            rd_data = (rd_sel == SelCntHi) ? snap_q[k][63:32] : snap_q[k][31:0];
          end
        end
      end
      default: begin
        rd_err  = 1'b1;
        rd_data = DefaultRdata;
      end
    endcase
  end

  always_comb begin
    case (wr_sel)
      SelChanSel:                      wr_err = ({28'h0, wr_data[3:0]} >= C_NUM_CHANNELS);
      SelSnapshot, SelControl, SelClear: wr_err = 1'b0;
      default:                         wr_err = 1'b1;
    endcase
  end

  always_comb begin
    chan_sel_d = chan_sel_q;
    control_d  = control_q;
    snap_d     = snap_q;
    clear_d    = '0;
    fb_addr_d  = fb_addr_q;
    rd_fbuf_d  = rd_fbuf_q;

    if (rd_done && rd_fbuf_q) begin
      fb_addr_d = fb_addr_q + FBW'(1);
    end
    if (rd_en) begin
      rd_fbuf_d = (rd_sel == SelFrameBuf);
      if (rd_sel == SelFrameSize) begin
        fb_addr_d = '0;
      end
    end

    if (wr_en && !wr_err) begin
      case (wr_sel)
        SelChanSel: begin
          chan_sel_d = wr_data[3:0];
          fb_addr_d  = '0;
        end
        SelSnapshot: begin
          for (int c = 0; c < C_NUM_CHANNELS; c++) begin
            for (int k = 0; k < C_NUM_COUNTERS; k++) begin
              if (wr_data[0] && chan_sel_q == 4'(c)) begin
                snap_d[k] = counters[(c*C_NUM_COUNTERS+k)*64 +: 64];
              end
            end
          end
        end
        SelControl: begin
          for (int c = 0; c < C_NUM_CHANNELS; c++) begin
            for (int b = 0; b < 4; b++) begin
              if (chan_sel_q == 4'(c) && wr_strb[b]) begin
                control_d[c][8*b +: 8] = wr_data[8*b +: 8];
              end
            end
          end
        end
        SelClear: begin
          for (int c = 0; c < C_NUM_CHANNELS; c++) begin
            if (wr_data[0] && chan_sel_q == 4'(c)) begin
              clear_d[c] = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      chan_sel_q <= 4'h0;
      control_q  <= {C_NUM_CHANNELS{32'h1}};
      snap_q     <= '0;
      clear_q    <= '0;
      fb_addr_q  <= '0;
      rd_fbuf_q  <= 1'b0;
    end else begin
      chan_sel_q <= chan_sel_d;
      control_q  <= control_d;
      snap_q     <= snap_d;
      clear_q    <= clear_d;
      fb_addr_q  <= fb_addr_d;
      rd_fbuf_q  <= rd_fbuf_d;
    end
  end

  assign control           = control_q;
  assign counters_clear    = clear_q;
  assign frame_buf_address = fb_addr_q;
  assign chan_sel          = chan_sel_q;

endmodule

// File: tb/tb_traffic_analyzer_mc_cpu_regs.sv
// Self-checking bench: table-driven register accesses with a response
// scoreboard, plus sequences for snapshot, frame buffer, clear and reset.
module tb_traffic_analyzer_mc_cpu_regs;

  localparam int unsigned NCH  = 4;
  localparam int unsigned NCNT = 8;
  localparam int unsigned FBW  = 9;
  localparam int          T    = 100;
  localparam logic [31:0] IdVal  = 32'h7A11_C0DE;
  localparam logic [31:0] VerVal = 32'h0001_0203;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [NCH*NCNT*64-1:0] counters = '0;
  logic [NCH*32-1:0]      control;
  logic [NCH-1:0]         counters_clear;
  logic [NCH*32-1:0]      frame_size;
  logic [31:0]            frame_buf_data;
  logic [FBW-1:0]         frame_buf_address;
  logic [3:0]             chan_sel;

  always #5 clk = ~clk;

  assign frame_size     = {32'h4400_0400, 32'h3300_0300, 32'h2200_0200, 32'h1100_0100};
  assign frame_buf_data = 32'hF000_0000 | 32'(frame_buf_address);

  traffic_analyzer_mc_cpu_regs dut (
    .S_AXI_ACLK        (clk),
    .S_AXI_ARESETN     (rst_n),
    .S_AXI_AWADDR      (awaddr),
    .S_AXI_AWPROT      (3'b000),
    .S_AXI_AWVALID     (awvalid),
    .S_AXI_AWREADY     (awready),
    .S_AXI_WDATA       (wdata),
    .S_AXI_WSTRB       (wstrb),
    .S_AXI_WVALID      (wvalid),
    .S_AXI_WREADY      (wready),
    .S_AXI_BRESP       (bresp),
    .S_AXI_BVALID      (bvalid),
    .S_AXI_BREADY      (bready),
    .S_AXI_ARADDR      (araddr),
    .S_AXI_ARPROT      (3'b000),
    .S_AXI_ARVALID     (arvalid),
    .S_AXI_ARREADY     (arready),
    .S_AXI_RDATA       (rdata),
    .S_AXI_RRESP       (rresp),
    .S_AXI_RVALID      (rvalid),
    .S_AXI_RREADY      (rready),
    .id_reg            (IdVal),
    .version_reg       (VerVal),
    .counters          (counters),
    .control           (control),
    .counters_clear    (counters_clear),
    .frame_size        (frame_size),
    .frame_buf_data    (frame_buf_data),
    .frame_buf_address (frame_buf_address),
    .chan_sel          (chan_sel)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0]  wr_q[$];
  logic [33:0] rd_q[$];

  int       clr_total = 0;
  logic [3:0] clr_last = '0;
  always @(negedge clk) begin
    if (counters_clear != '0) begin
      clr_total <= clr_total + 1;
      clr_last  <= counters_clear;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input string name);
    int n;
    logic [1:0] e;
    wr_q.push_back(exp_resp);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(awready && wready) && n < T);
    if (!(awready && wready)) begin
      check({name, ".awready"}, 64'(awready), 64'd1);
      awvalid = 1'b0; wvalid = 1'b0;
      e = wr_q.pop_front();
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < T) begin @(negedge clk); n++; end
    e = wr_q.pop_front();
    if (!bvalid) begin
      check({name, ".bvalid"}, 64'(bvalid), 64'd1);
      return;
    end
    check({name, ".bresp"}, 64'(bresp), 64'(e));
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [11:0] addr, input int hold, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string name);
    int n;
    logic [33:0] e;
    rd_q.push_back({exp_data, exp_resp});
    araddr = addr; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!arready && n < T);
    if (!arready) begin
      check({name, ".arready"}, 64'(arready), 64'd1);
      arvalid = 1'b0;
      e = rd_q.pop_front();
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < T) begin @(negedge clk); n++; end
    e = rd_q.pop_front();
    if (!rvalid) begin
      check({name, ".rvalid"}, 64'(rvalid), 64'd1);
      return;
    end
    repeat (hold) @(negedge clk);
    check({name, ".rdata"}, 64'(rdata), 64'(e[33:2]));
    check({name, ".rresp"}, 64'(rresp), 64'(e[1:0]));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  typedef struct {
    logic        is_wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    string       name;
  } vec_t;

  function automatic vec_t mk(input logic is_wr, input logic [11:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp, input string name);
    vec_t v;
    v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb;
    v.exp_data = exp_data; v.exp_resp = exp_resp; v.name = name;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    int base;
    vecs.push_back(mk(1'b0, 12'h010, 32'h0,         4'h0, 32'h1,         2'b00, "ctrl_reset"));
    vecs.push_back(mk(1'b0, 12'h000, 32'h0,         4'h0, IdVal,         2'b00, "id"));
    vecs.push_back(mk(1'b0, 12'h004, 32'h0,         4'h0, VerVal,        2'b00, "version"));
    vecs.push_back(mk(1'b0, 12'h204, 32'h0,         4'h0, 32'h0,         2'b00, "snap_reset"));
    vecs.push_back(mk(1'b1, 12'h010, 32'hAABBCCDD,  4'b0101, 32'h0,      2'b00, "ctrl_wr_strb"));
    vecs.push_back(mk(1'b0, 12'h010, 32'h0,         4'h0, 32'h00BB00DD,  2'b00, "ctrl_rd_strb"));
    vecs.push_back(mk(1'b1, 12'h008, 32'h9,         4'hF, 32'h0,         2'b10, "chsel_bad"));
    vecs.push_back(mk(1'b0, 12'h008, 32'h0,         4'h0, 32'h0,         2'b00, "chsel_kept"));
    vecs.push_back(mk(1'b0, 12'h3FC, 32'h0,         4'h0, 32'hDEADBEEF,  2'b10, "unmapped"));
    vecs.push_back(mk(1'b0, 12'h240, 32'h0,         4'h0, 32'hDEADBEEF,  2'b10, "cnt_range"));
    vecs.push_back(mk(1'b1, 12'h008, 32'hFFFFFFF2,  4'h0, 32'h0,         2'b00, "chsel_wr"));
    vecs.push_back(mk(1'b0, 12'h008, 32'h0,         4'h0, 32'h2,         2'b00, "chsel_rd"));
    vecs.push_back(mk(1'b0, 12'h010, 32'h0,         4'h0, 32'h1,         2'b00, "ctrl_ch2"));
    vecs.push_back(mk(1'b0, 12'h100, 32'h0,         4'h0, 32'h3300_0300, 2'b00, "fsize_ch2"));

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst.awready", 64'(awready), 64'd0);
    check("rst.bvalid", 64'(bvalid), 64'd0);
    check("rst.arready", 64'(arready), 64'd0);
    check("rst.rvalid", 64'(rvalid), 64'd0);
    check("rst.rdata", 64'(rdata), 64'd0);
    check("rst.chan_sel", 64'(chan_sel), 64'd0);
    check("rst.fb_addr", 64'(frame_buf_address), 64'd0);
    check("rst.clear", 64'(counters_clear), 64'd0);
    for (int c = 0; c < NCH; c++) check("rst.control", 64'(control[c*32 +: 32]), 64'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].is_wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].exp_resp,
                                   vecs[i].name);
      else axi_read(vecs[i].addr, 0, vecs[i].exp_data, vecs[i].exp_resp, vecs[i].name);
    end
    check("control_port_ch0", 64'(control[31:0]), 64'h00BB00DD);
    check("control_port_ch2", 64'(control[95:64]), 64'h1);
    check("chan_sel_port", 64'(chan_sel), 64'd2);

    // Snapshot must hold values latched at the write, not live counters.
    counters[(2*NCNT+3)*64 +: 64] = 64'h1_0000_0005;
    counters[(2*NCNT+7)*64 +: 64] = 64'hABCD_0000_1234_5678;
    counters[(1*NCNT+3)*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(12'h00C, 32'h1, 4'h0, 2'b00, "snapshot");
    counters[(2*NCNT+3)*64 +: 64] = 64'h0;
    axi_read(12'h218, 0, 32'h1, 2'b00, "cnt3_hi");
    axi_read(12'h21C, 0, 32'h5, 2'b00, "cnt3_lo");
    axi_read(12'h238, 0, 32'hABCD_0000, 2'b00, "cnt7_hi");
    axi_read(12'h23C, 0, 32'h1234_5678, 2'b00, "cnt7_lo");

    // Same-edge read and write of CONTROL: read sees the old value.
    fork
      axi_write(12'h010, 32'h1234_5678, 4'hF, 2'b00, "rw_wr");
      axi_read(12'h010, 0, 32'h1, 2'b00, "rw_rd_old");
    join
    axi_read(12'h010, 0, 32'h1234_5678, 2'b00, "rw_rd_new");

    // Frame buffer walk across the wrap point with stalled RREADY.
    axi_read(12'h100, 0, 32'h3300_0300, 2'b00, "fsize_zero");
    check("fb_addr_after_fsize", 64'(frame_buf_address), 64'd0);
    for (int i = 0; i < (1 << FBW) + 1; i++) begin
      axi_read(12'h104, 3, 32'hF000_0000 | 32'(i % (1 << FBW)), 2'b00, "fbuf");
      check("fb_addr_step", 64'(frame_buf_address), 64'((i + 1) % (1 << FBW)));
    end
    axi_read(12'h100, 0, 32'h3300_0300, 2'b00, "fsize_rezero");
    check("fb_addr_rezero", 64'(frame_buf_address), 64'd0);
    axi_read(12'h104, 0, 32'hF000_0000, 2'b00, "fbuf_again");
    check("fb_addr_one", 64'(frame_buf_address), 64'd1);
    axi_write(12'h008, 32'h1, 4'hF, 2'b00, "chsel_1");
    check("fb_addr_chsel_zero", 64'(frame_buf_address), 64'd0);

    // CLEAR pulse on the selected channel only, one cycle long.
    base = clr_total;
    axi_write(12'h014, 32'h1, 4'h0, 2'b00, "clear");
    repeat (3) @(negedge clk);
    check("clear_cycles", 64'(clr_total - base), 64'd1);
    check("clear_value", 64'(clr_last), 64'b0010);

    // Reset while a write response is pending.
    awaddr = 12'h010; wdata = 32'h5A; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    base = 0;
    do begin @(negedge clk); base++; end while (!awready && base < T);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    check("bvalid_pending", 64'(bvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("bvalid_in_reset", 64'(bvalid), 64'd0);
    check("chan_sel_in_reset", 64'(chan_sel), 64'd0);
    check("control_in_reset", 64'(control[63:32]), 64'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("bvalid_after_reset", 64'(bvalid), 64'd0);
    bready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_analyzer_mc_cpu_regs.md
TRAFFIC_ANALYZER_MC_CPU_REGS -- requirements
Module: traffic_analyzer_mc_cpu_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width; only 32 is supported.
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, AXI-Lite address width.
REQ-003 SHALL have parameter C_BASE_ADDRESS, default 32'h0, XORed onto incoming addresses.
REQ-004 SHALL have parameter C_NUM_CHANNELS, default 4, range 1..16, number of analyzer channels.
REQ-005 SHALL have parameter C_NUM_COUNTERS, default 8, range 1..16, number of 64-bit counters per channel.
REQ-006 SHALL have parameter C_FRAME_BUF_ADDRESS_WIDTH, default 9, frame buffer word-address width.
REQ-007 SHALL have ports: S_AXI_ACLK in 1, sole clock; S_AXI_ARESETN in 1, asynchronous active-low reset.
REQ-008 SHALL have the AXI-Lite slave channel ports S_AXI_AW*/W*/B*/AR*/R* at standard widths.
REQ-009 SHALL have ports: id_reg in 32 and version_reg in 32, constants.
REQ-010 SHALL have port counters in C_NUM_CHANNELS*C_NUM_COUNTERS*64, live counters; channel c, counter k at offset (c*C_NUM_COUNTERS+k)*64.
REQ-011 SHALL have port control out C_NUM_CHANNELS*32, per-channel control words.
REQ-012 SHALL have port counters_clear out C_NUM_CHANNELS, one-cycle clear pulses.
REQ-013 SHALL have ports: frame_size in C_NUM_CHANNELS*32; frame_buf_data in 32, read data for the selected channel.
REQ-014 SHALL have ports: frame_buf_address out C_FRAME_BUF_ADDRESS_WIDTH; chan_sel out 4, the selected channel.

Function
REQ-015 Address map, after XOR with C_BASE_ADDRESS, SHALL be: 0x000 ID (RO); 0x004 VERSION (RO); 0x008 CHAN_SEL (RW, bits 3:0); 0x00C SNAPSHOT (WO); 0x010 CONTROL (RW, selected channel); 0x014 CLEAR (WO); 0x100 FRAME_SIZE (RO); 0x104 FRAME_BUF (RO).
REQ-016 Counter k SHALL read at 0x200+8k as the high word and at 0x204+8k as the low word, both taken from the snapshot registers.
REQ-017 A write of bit0=1 to SNAPSHOT SHALL latch all C_NUM_COUNTERS counters of the selected channel in the same cycle, so that 64-bit reads are atomic.
REQ-018 A write of bit0=1 to CLEAR SHALL pulse counters_clear[chan_sel] high for exactly one cycle, on the cycle after the write handshake.
REQ-019 The write path SHALL accept only when AWVALID and WVALID are both high: AWREADY and WREADY pulse together for 1 cycle, then BVALID rises the next cycle and holds until BREADY.
REQ-020 The read path SHALL pulse ARREADY for 1 cycle on ARVALID; RVALID SHALL rise the following cycle with registered RDATA and hold until RREADY. One transaction is outstanding per channel.
REQ-021 CONTROL writes SHALL honour WSTRB per byte; CHAN_SEL, SNAPSHOT and CLEAR SHALL use bits as stated and ignore WSTRB.
REQ-022 Unmapped addresses, counter index >= C_NUM_COUNTERS, or a CHAN_SEL write value >= C_NUM_CHANNELS SHALL give RRESP/BRESP=2'b10 with no state change; unmapped reads return 32'hDEADBEEF.
REQ-023 A read of FRAME_SIZE SHALL zero frame_buf_address; each completed FRAME_BUF read (RVALID&RREADY) SHALL increment it by 1, wrapping from 2^W-1 to 0.
REQ-024 A write of CHAN_SEL SHALL zero frame_buf_address.
REQ-025 On a simultaneous read and write of the same register, the read SHALL return the pre-write value.

Reset
REQ-026 While S_AXI_ARESETN is low, all READY/VALID outputs, RESP, RDATA, chan_sel, frame_buf_address, counters_clear and the snapshot registers SHALL be 0, and every control word SHALL be 32'h1.
REQ-027 Reset asserted mid-transaction SHALL abort the transaction; no pending response SHALL appear after release.

Structure
REQ-028 Register offsets, the 0xDEADBEEF default and RESP codes SHALL live in shared package traffic_analyzer_mc_regs_pkg.
REQ-029 AXI-Lite handshake logic SHALL live in sub-module traffic_analyzer_axil_slave, which exposes wr_en/wr_addr/wr_data/wr_strb, rd_en/rd_addr and rd_data/rd_err.

Verification
REQ-030 Reset, then read 0x010 -> 32'h1, OKAY; read 0x000 -> id_reg.
REQ-031 Write CHAN_SEL=2; set counter 3 of channel 2 = 64'h1_0000_0005; write SNAPSHOT=1; change counter to 0; read 0x218/0x21C -> 32'h1 / 32'h5.
REQ-032 Write CHAN_SEL=9 with C_NUM_CHANNELS=4 -> BRESP 2'b10 and chan_sel unchanged; read 0x3FC -> 32'hDEADBEEF, RRESP 2'b10.
REQ-033 Read FRAME_SIZE, then 2^W+1 FRAME_BUF reads with RREADY held low 3 cycles each -> frame_buf_address sequence 0,1,...,2^W-1,0,1, one increment per handshake.
REQ-034 Write CLEAR=1 with chan_sel=1 -> counters_clear=4'b0010 for exactly one cycle.
REQ-035 Assert reset during BVALID-pending -> BVALID 0 immediately and after release.
